// File: rtl/rom_arbiter_pkg.sv
// rom_arb_pkg: shared defaults and helpers for the ROM arbiter slice.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package rom_arb_pkg;

  localparam int NREQ_MAX       = 8;
  localparam int DEF_NREQ       = 2;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_LAT    = 1;

  // One-hot to binary index; input assumed one-hot (all-zero yields 0).
  function automatic logic [2:0] onehot_to_index(input logic [NREQ_MAX-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, scans from ptr_i upward with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; gnt_o is all-zero when no request is present.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  logic found;
  int   j;

  // First requester at or after the pointer (modulo NREQ) wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign idx_o = PTR_W'(onehot_to_index(NREQ_MAX'(gnt_o)));

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one fixed-latency ROM; optional burst lock via ROM_ARB_LOCK_EN.
// Latency: grant/address combinational; rvalid/rdata MEM_LAT cycles after the accepting cycle.
// Backpressure: req held until gnt; one access per cycle, returns in acceptance order.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_LAT    = DEF_MEM_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
`ifdef ROM_ARB_LOCK_EN
  input  logic [NREQ-1:0]            lock,
`endif
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      mem_q
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  rr_gnt;
  logic [PTR_W-1:0] rr_idx;
  logic [PTR_W-1:0] win_idx;
  logic             accept;
  logic             hold;
  logic [NREQ-1:0]  hold_gnt;
  logic [PTR_W-1:0] hold_idx;
  logic [NREQ-1:0]  tag_q [MEM_LAT];

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

`ifdef ROM_ARB_LOCK_EN
  logic [PTR_W-1:0] own_q;
  logic             own_vld_q;

  // Owner stays locked only while it was accepted last cycle and still requests with lock.
  assign hold     = own_vld_q & req[own_q] & lock[own_q];
  assign hold_gnt = NREQ'(1) << own_q;
  assign hold_idx = own_q;

  // Track who was accepted last cycle; a cycle without acceptance drops ownership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_q     <= '0;
      own_vld_q <= 1'b0;
    end else begin
      own_q     <= win_idx;
      own_vld_q <= accept;
    end
  end
`else
  assign hold     = 1'b0;
  assign hold_gnt = '0;
  assign hold_idx = '0;
`endif

  // Grant select and address mux; everything held quiet while reset is asserted.
  always_comb begin
    gnt      = rst_n ? (hold ? hold_gnt : rr_gnt) : '0;
    win_idx  = hold ? hold_idx : rr_idx;
    accept   = |gnt;
    mem_addr = accept ? addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    ptr_d    = ptr_q;
    if (accept && !hold) begin
      ptr_d = (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer register and MEM_LAT-deep one-hot tag pipeline aligned with ROM latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tag_q[0] <= gnt;
      for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // In-flight returns are suppressed while reset is asserted.
  assign rvalid = rst_n ? tag_q[MEM_LAT-1] : '0;
  assign rdata  = mem_q;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  typedef struct {
    int          due;
    logic [1:0]  tag;
    logic [DW-1:0] dat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  // DUT with MEM_LAT=1
  logic          rst_n;
  logic [1:0]    req;
  logic [2*AW-1:0] addr;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata, mem_q;
  logic [AW-1:0] mem_addr;
  // DUT with MEM_LAT=3
  logic          rst3_n;
  logic [1:0]    req3;
  logic [2*AW-1:0] addr3;
  logic [1:0]    gnt3, rvalid3;
  logic [DW-1:0] rdata3, mem_q3, p3a, p3b;
  logic [AW-1:0] mem_addr3;
`ifdef ROM_ARB_LOCK_EN
  logic [1:0]    lock, lock3;
`endif

  rom_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
`ifdef ROM_ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_q(mem_q)
  );

  rom_arbiter #(.NREQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .addr(addr3),
`ifdef ROM_ARB_LOCK_EN
    .lock(lock3),
`endif
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .mem_addr(mem_addr3), .mem_q(mem_q3)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {25'd0, a};
  endfunction

  // ROM models: 1-cycle and 3-cycle latency
  always @(posedge clk) mem_q <= rom_f(mem_addr);
  always @(posedge clk) begin
    p3a    <= rom_f(mem_addr3);
    p3b    <= p3a;
    mem_q3 <= p3b;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Monitors: pop expected returns whenever a DUT presents rvalid
  always @(negedge clk) begin
    if (rvalid !== 2'b00) begin
      if (q1.size() == 0) chk("rvalid_unexpected", {30'd0, rvalid}, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("rvalid_cycle", cyc, e1.due);
        chk("rvalid_tag", {30'd0, rvalid}, {30'd0, e1.tag});
        chk("rdata", rdata, e1.dat);
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid3 !== 2'b00) begin
      if (q3.size() == 0) chk("lat3_rvalid_unexpected", {30'd0, rvalid3}, 32'd0);
      else begin
        e3 = q3.pop_front();
        chk("lat3_rvalid_cycle", cyc, e3.due);
        chk("lat3_rvalid_tag", {30'd0, rvalid3}, {30'd0, e3.tag});
        chk("lat3_rdata", rdata3, e3.dat);
      end
    end
  end

  // One cycle of stimulus on the MEM_LAT=1 DUT with expected grant; ret pushes a return.
  task automatic step(input logic r, input logic [1:0] rq, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic [1:0] eg, input bit ret,
                      input string nm);
    logic [AW-1:0] ea;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    req   = rq;
    addr  = {a1, a0};
    @(negedge clk);
    chk({nm, "_gnt"}, {30'd0, gnt}, {30'd0, eg});
    ea = eg[0] ? a0 : (eg[1] ? a1 : '0);
    chk({nm, "_mem_addr"}, {25'd0, mem_addr}, {25'd0, ea});
    if (ret && eg != 2'b00) begin
      e.due = cyc + 1;
      e.tag = eg;
      e.dat = rom_f(ea);
      q1.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; req = '0; addr = '0;
    rst3_n = 1'b0; req3 = '0; addr3 = '0;
`ifdef ROM_ARB_LOCK_EN
    lock = '0; lock3 = '0;
`endif
    fork
      begin
        // reset with both requesting
        step(1'b0, 2'b11, 7'd1, 7'd2, 2'b00, 0, "rst_a");
        chk("rst_a_rvalid", {30'd0, rvalid}, 32'd0);
        step(1'b0, 2'b11, 7'd1, 7'd2, 2'b00, 0, "rst_b");
        chk("rst_b_rvalid", {30'd0, rvalid}, 32'd0);
        // contention: alternate 0,1,0,1
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 1, "cont0");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "cont1");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 1, "cont2");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "cont3");
        // single requester 0 back-to-back
        step(1'b1, 2'b01, 7'd5, 7'd0, 2'b01, 1, "single5");
        step(1'b1, 2'b01, 7'd6, 7'd0, 2'b01, 1, "single6");
        step(1'b1, 2'b01, 7'd7, 7'd0, 2'b01, 1, "single7");
        // single requester 1 regardless of pointer
        step(1'b1, 2'b10, 7'd0, 7'd9, 2'b10, 1, "only1_a");
        step(1'b1, 2'b10, 7'd0, 7'd10, 2'b10, 1, "only1_b");
        // idle keeps pointer
        step(1'b1, 2'b01, 7'd3, 7'd0, 2'b01, 1, "r0");
        step(1'b1, 2'b00, 7'd3, 7'd8, 2'b00, 0, "idle");
        step(1'b1, 2'b11, 7'd4, 7'd8, 2'b10, 1, "after_idle");
        // requester 1 drops before grant
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 1, "drop_a");
        step(1'b1, 2'b01, 7'd3, 7'd2, 2'b01, 1, "drop_b");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "drop_c");
        // mid-operation reset discards in-flight return and resets pointer
        step(1'b1, 2'b01, 7'd6, 7'd0, 2'b01, 0, "pre_rst");
        step(1'b0, 2'b11, 7'd1, 7'd2, 2'b00, 0, "mid_rst");
        chk("mid_rst_rvalid", {30'd0, rvalid}, 32'd0);
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 1, "post_rst");
        step(1'b1, 2'b00, 7'd0, 7'd0, 2'b00, 0, "drain_a");
`ifdef ROM_ARB_LOCK_EN
        lock = 2'b10;
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "lock0");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "lock1");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "lock2");
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b10, 1, "lock3");
        lock = 2'b00;
        step(1'b1, 2'b11, 7'd1, 7'd2, 2'b01, 1, "unlock");
`endif
        repeat (4) step(1'b1, 2'b00, 7'd0, 7'd0, 2'b00, 0, "drain_b");
      end
      begin
        // MEM_LAT=3: accept exactly at cycle 10, return exactly at cycle 13
        repeat (2) @(posedge clk);
        #1 rst3_n = 1'b1;
        do begin
          @(posedge clk);
          #1;
        end while (cyc != 10);
        req3  = 2'b01;
        addr3 = {7'd0, 7'd4};
        @(negedge clk);
        chk("lat3_gnt", {30'd0, gnt3}, 32'd1);
        e.due = cyc + 3;
        e.tag = 2'b01;
        e.dat = rom_f(7'd4);
        q3.push_back(e);
        @(posedge clk);
        #1 req3 = 2'b00;
      end
    join
    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
